// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises the PLL lock flag, holds the sound-core reset until lock has
// been stable long enough, and re-pulses the PLL reset on lock timeout or lock loss.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] relock_count
);

  typedef enum logic [1:0] {StPllReset, StWaitLock, StStabilize, StRun} state_e;

  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
  logic [7:0]       relock_q, relock_d;
  logic             relock_inc;

  logic pll_rst_q, pll_rst_d;
  logic sys_rst_n_q, sys_rst_n_d;
  logic ready_q, ready_d;
  logic lock_lost_q, lock_lost_d;

  // Raw pll_locked is only ever seen by the first synchroniser flop.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lk = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    relock_inc = 1'b0;
    cnt_last   = '1;
    case (state_q)
      StPllReset: begin
        cnt_last = RstLast;
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        cnt_last = TimeoutLast;
        // Lock arriving on the timeout cycle takes priority over the retry.
        if (lk) begin
          state_d = StStabilize;
        end else if (cnt_q == TimeoutLast) begin
          state_d    = StPllReset;
          relock_inc = 1'b1;
        end
      end
      StStabilize: begin
        cnt_last = StableLast;
        if (!lk) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lk) begin
          state_d    = StPllReset;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_d = StPllReset;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != cnt_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    relock_d = relock_q;
    if (relock_inc && (relock_q != 8'hff)) begin
      relock_d = relock_q + 8'd1;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_rst_d   = (state_d == StPllReset);
    sys_rst_n_d = (state_d == StRun);
    ready_d     = (state_d == StRun);
    lock_lost_d = (state_q == StRun) && (state_d == StPllReset);
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= StPllReset;
      cnt_q       <= '0;
      relock_q    <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      relock_q    <= relock_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst_n    = sys_rst_n_q;
  assign ready        = ready_q;
  assign lock_lost    = lock_lost_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: stimulus queues the expected output changes (edge number and values);
// a negedge monitor pops one entry every time any output changes and compares.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] relock_count;

  pll_lock_supervisor #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (16),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (1024),
    .CNT_W              (20)
  ) u_dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .relock_count(relock_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    string       tag;
    int unsigned edge_no;
    logic [11:0] vals;  // {pll_rst, sys_rst_n, ready, lock_lost, relock_count}
  } ev_t;

  ev_t         exp_q[$];
  int unsigned n_vec  = 0;
  int unsigned n_bad  = 0;
  int unsigned edge_n = 0;

  always @(posedge refclk) edge_n <= edge_n + 1;

  task automatic push(input string tag, input int unsigned e, input logic pr, input logic sr,
                      input logic rdy, input logic ll, input logic [7:0] rc);
    ev_t ev;
    ev.tag     = tag;
    ev.edge_no = e;
    ev.vals    = {pr, sr, rdy, ll, rc};
    exp_q.push_back(ev);
  endtask

  task automatic go_to(input int unsigned e);
    while (edge_n < e) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Monitor
  logic [11:0] cur, prev;
  logic        first = 1'b1;
  ev_t         got_ev;

  initial begin
    forever begin
      @(negedge refclk);
      cur = {pll_rst, sys_rst_n, ready, lock_lost, relock_count};
      if (first || (cur != prev)) begin
        first = 1'b0;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: edge %0d got pr/sr/rdy/ll=%b rc=%0d, required none",
                   edge_n, cur[11:8], cur[7:0]);
        end else begin
          got_ev = exp_q.pop_front();
          if ((got_ev.edge_no != edge_n) || (got_ev.vals != cur)) begin
            n_bad++;
            $display("FAIL %s: got edge %0d pr/sr/rdy/ll=%b rc=%0d, required edge %0d %b rc=%0d",
                     got_ev.tag, edge_n, cur[11:8], cur[7:0], got_ev.edge_no,
                     got_ev.vals[11:8], got_ev.vals[7:0]);
          end
        end
      end
      prev = cur;
    end
  end

  int unsigned p, w;
  int unsigned rc;

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;

    // Reset values, then release; PLL reports lock as soon as its reset is released.
    push("reset_values", 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    go_to(2);
    rst_n = 1'b1;
    push("t1_pll_rst_fall", 18, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    push("t1_run", 18 + 1027, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    go_to(18);
    pll_locked = 1'b1;

    // One-cycle drop in RUN.
    push("t3_lock_lost", 1053, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    push("t3_pulse_end", 1054, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    push("t3_pll_rst_fall", 1069, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    // Mid-stabilise glitch restarts at 1574; final-stable-cycle glitch restarts at 2599.
    push("t4_t6b_run", 2599 + 1024, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
    go_to(1050);
    pll_locked = 1'b0;
    go_to(1051);
    pll_locked = 1'b1;
    go_to(1570);
    pll_locked = 1'b0;
    go_to(1571);
    pll_locked = 1'b1;
    go_to(2595);
    pll_locked = 1'b0;
    go_to(2596);
    pll_locked = 1'b1;

    // Reset pulse while in RUN, sequence replays with lock already present.
    go_to(3630);
    rst_n = 1'b0;
    push("t5_reset", 3631, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    push("t5_pll_rst_fall", 3647, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    push("t5_run", 3648 + 1024, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    go_to(3631);
    rst_n = 1'b1;

    // Lock lost for good: timeouts every 16+32 cycles, count saturating at 255.
    go_to(4680);
    pll_locked = 1'b0;
    push("t2_lock_lost", 4683, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    push("t2_pulse_end", 4684, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    push("t2_wait_lock", 4699, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int k = 0; k < 258; k++) begin
      p  = 4731 + 48 * k;
      rc = (k + 2 > 255) ? 255 : k + 2;
      push("t2_timeout", p, 1'b1, 1'b0, 1'b0, 1'b0, rc[7:0]);
      push("t2_wait_lock", p + 16, 1'b0, 1'b0, 1'b0, 1'b0, rc[7:0]);
    end
    w = 4731 + 48 * 257 + 16;

    // Lock arrives exactly on the timeout cycle.
    push("t6a_run", w + 32 + 1024, 1'b0, 1'b1, 1'b1, 1'b0, 8'd255);
    go_to(w + 29);
    pll_locked = 1'b1;

    go_to(w + 32 + 1024 + 10);
    while (exp_q.size() != 0) begin
      got_ev = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: got no change by edge %0d, required change at edge %0d",
               got_ev.tag, edge_n, got_ev.edge_no);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
